minmax_tracker: RTL and testbench
=================================

// Module: minmax_tracker
// PURPOSE
//   Streaming min/max tracker downstream of the 4-bit magnitude comparator stage.
//   Accepts a frame of COUNT unsigned samples over a valid/ready handshake.
//   Compares each sample against the running max and min using
//   equals/larger/smaller semantics.
//   Presents the frame's max, min and an all-equal flag on a held output handshake.
// PARAMETERS
//   WIDTH  4  sample width in bits; unsigned magnitude
//   COUNT  8  samples per frame; legal range >= 1
// PORTS
//   clk           input   1      single clock; all state updates on rising edge
//   rst           input   1      synchronous, active-high reset
//   in_valid      input   1      in_data is valid this cycle
//   in_ready      output  1      block can accept a sample this cycle
//   in_data       input   WIDTH  sample value, unsigned
//   out_valid     output  1      frame result is valid and held
//   out_ready     input   1      consumer accepts the result this cycle
//   out_max       output  WIDTH  largest sample in the frame
//   out_min       output  WIDTH  smallest sample in the frame
//   out_all_equal output  1      1 when every sample in the frame was equal (max == min)
// BEHAVIOUR
//   Reset values
//     - rst=1 at a clock edge forces: state=FIRST, count=0, out_valid=0, out_max=0,
//       out_min=0, out_all_equal=0.
//     - in_ready is a decode of state, so it reads 1 the cycle after reset.
//     - Reset mid-frame or while holding a result discards all partial/unread data.
//   Sample acceptance
//     - A sample is accepted when in_valid & in_ready at a rising edge.
//     - in_ready is 1 in FIRST and ACCUM, 0 in HOLD; it has no combinational path
//       from in_valid.
//   States
//     - FIRST: on accept, max_r=min_r=in_data and count=1.
//       Goes to HOLD if COUNT==1, else ACCUM.
//     - ACCUM: on accept, compare in_data against max_r and min_r:
//       - if in_data > max_r (larger), max_r <= in_data;
//       - if in_data < min_r (smaller), min_r <= in_data;
//       - if equal, no update.
//       count increments. When the accepted sample is the COUNT-th, go to HOLD.
//     - HOLD: out_valid=1. out_max/out_min/out_all_equal stay stable while
//       out_valid & !out_ready. On out_valid & out_ready, go to FIRST and clear
//       out_valid the next cycle.
//   Latency and throughput
//     - out_valid rises the cycle after the COUNT-th sample is accepted.
//     - Best-case throughput is COUNT+1 cycles per frame: one bubble for the result
//       handshake, and no sample is accepted in the cycle the result is taken.
//   Arithmetic
//     - All comparisons are unsigned over the full WIDTH; no sign extension.
//     - count is $clog2(COUNT+1) bits wide and never exceeds COUNT.
//   Outputs
//     - out_max, out_min and out_all_equal are registered and loaded on the
//       ACCUM/FIRST -> HOLD transition.
//     - out_all_equal = (max_r == min_r) after the final update.
//   Boundary values
//     - Samples of 0 and 2^WIDTH-1 are legal extremes.
//     - A frame of all-max values gives out_max=out_min=2^WIDTH-1 and out_all_equal=1.
//   Stalls
//     - in_valid low stalls accumulation indefinitely; state is retained.
//     - out_ready low stalls HOLD indefinitely; in_ready stays 0 throughout.
//   X-propagation
//     - in_data is ignored when in_valid=0; X on in_data is allowed then.
// TESTING
//   1. Reset then frame {3,9,1,7,7,0xF,2,5}, out_ready=1
//      -> out_valid 1 cycle after 8th accept, out_max=0xF, out_min=1, out_all_equal=0.
//   2. Frame of eight 0x6 values
//      -> out_max=6, out_min=6, out_all_equal=1.
//   3. Result held with out_ready=0 for 5 cycles while in_valid=1
//      -> in_ready=0, outputs stable, no sample consumed.
//      Release out_ready -> next cycle state FIRST, in_ready=1.
//   4. Random in_valid gaps (~50%) over 4 frames
//      -> results match a scoreboard model; count never exceeds 8.
//   5. rst=1 after the 4th sample of a frame
//      -> next cycle out_valid=0, in_ready=1.
//      Following frame {8,8,8,8,8,8,8,0} gives out_max=8, out_min=0 (no stale data).
//   6. COUNT=1 build, samples 0xA then 0x0
//      -> two results: max=min=0xA then max=min=0; out_all_equal=1 for both.

Source files
------------

// File: rtl/minmax_tracker.sv
// Streaming min/max tracker: accumulates a frame of COUNT unsigned samples and
// presents the frame's max, min and all-equal flag on a held output handshake.
module minmax_tracker #(
  parameter int WIDTH = 4,
  parameter int COUNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic             out_all_equal
);

  localparam int CW = $clog2(COUNT + 1);

  localparam logic [1:0] ST_FIRST = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] LAST_IDX = CW'(COUNT - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_s;
  logic [WIDTH-1:0] max_r;
  logic [WIDTH-1:0] max_s;
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] min_s;
  logic             accept_s;
  logic             take_s;
  logic             last_s;

  // Ready is a pure state decode so it never depends on in_valid.
  assign in_ready = (state_r == ST_FIRST) || (state_r == ST_ACCUM);

  // Next-state, running extremes and sample count.
  always_comb begin
    accept_s = in_valid & in_ready;
    take_s   = out_valid & out_ready;
    state_s  = state_r;
    count_s  = count_r;
    max_s    = max_r;
    min_s    = min_r;
    last_s   = 1'b0;
    case (state_r)
      ST_FIRST: begin
        if (accept_s) begin
          max_s   = in_data;
          min_s   = in_data;
          count_s = CNT_ONE;
          last_s  = (COUNT == 1);
          state_s = last_s ? ST_HOLD : ST_ACCUM;
        end else begin
          state_s = ST_FIRST;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          max_s   = (in_data > max_r) ? in_data : max_r;
          min_s   = (in_data < min_r) ? in_data : min_r;
          count_s = count_r + CNT_ONE;
          last_s  = (count_r == LAST_IDX);
          state_s = last_s ? ST_HOLD : ST_ACCUM;
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (take_s) begin
          state_s = ST_FIRST;
          count_s = CNT_ZERO;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_FIRST;
        count_s = CNT_ZERO;
      end
    endcase
  end

  // State, accumulators and the registered result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_FIRST;
      count_r       <= CNT_ZERO;
      max_r         <= {WIDTH{1'b0}};
      min_r         <= {WIDTH{1'b0}};
      out_valid     <= 1'b0;
      out_max       <= {WIDTH{1'b0}};
      out_min       <= {WIDTH{1'b0}};
      out_all_equal <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      max_r   <= max_s;
      min_r   <= min_s;
      // Result is captured from the post-update extremes of the final sample.
      if (accept_s && last_s) begin
        out_valid     <= 1'b1;
        out_max       <= max_s;
        out_min       <= min_s;
        out_all_equal <= (max_s == min_s);
      end else if (take_s) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// Scoreboard bench for minmax_tracker: COUNT=8 instance for frame tests and a
// COUNT=1 instance for the single-sample frame case.
module tb_minmax_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_all_equal;
  logic [3:0] in_data, out_max, out_min;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, out_all_equal1;
  logic [3:0] in_data1, out_max1, out_min1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] sb_q[$];
  logic [8:0] sb1_q[$];
  logic [8:0] exp_v;
  bit         ok;

  minmax_tracker #(.WIDTH(4), .COUNT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min), .out_all_equal(out_all_equal)
  );

  minmax_tracker #(.WIDTH(4), .COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_max(out_max1), .out_min(out_min1), .out_all_equal(out_all_equal1)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drives n samples (nibble i of f is sample i); pushes the expected result for full frames.
  task automatic send_frame(input logic [31:0] f, input int n, input int gap_pct);
    logic [3:0] s, mx, mn;
    int w, g;
    mx = 4'h0;
    mn = 4'h0;
    for (int i = 0; i < n; i++) begin
      s = f[4*i +: 4];
      if (i == 0) begin
        mx = s;
        mn = s;
      end else begin
        if (s > mx) mx = s;
        if (s < mn) mn = s;
      end
      g = 0;
      while (g < 20 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 4'bxxxx;
        step();
        g++;
      end
      in_valid = 1'b1;
      in_data  = s;
      w = 0;
      while (!in_ready && w < 50) begin
        step();
        w++;
      end
      if (!in_ready) begin
        n_cmp++;
        n_bad++;
        $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      in_data  = 4'bxxxx;
      n_cmp++;
      if (dut.count_r > 4'd8) begin
        n_bad++;
        $display("FAIL count_bound: count=%0d required <=8", dut.count_r);
      end
    end
    if (n == 8) sb_q.push_back({mx, mn, (mx == mn)});
  endtask

  task automatic wait_result(output bit got);
    int t;
    t = 0;
    while (!out_valid && t < 100) begin
      step();
      t++;
    end
    got = out_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = 4'h0; out_ready1 = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, out_max, out_min, out_all_equal} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b max=%h min=%h eq=%b required all 0",
               out_valid, out_max, out_min, out_all_equal);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    n_cmp++;
    if ({out_valid1, in_ready1} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_count1: got v=%b rdy=%b required v=0 rdy=1", out_valid1, in_ready1);
    end
  endtask

  task automatic test_basic_frame;
    send_frame(32'h52F77193, 8, 0);
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_latency: out_valid=%b required 1 right after 8th accept", out_valid);
    end
    n_cmp++;
    if ({out_max, out_min, out_all_equal} !== exp_v) begin
      n_bad++;
      $display("FAIL basic_result: got %h/%h/%b required %h/%h/%b",
               out_max, out_min, out_all_equal, exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
    step();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL basic_release: got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_all_equal;
    send_frame(32'h66666666, 8, 0);
    wait_result(ok);
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (!ok || {out_max, out_min, out_all_equal} !== exp_v) begin
      n_bad++;
      $display("FAIL all_equal: got v=%b %h/%h/%b required %h/%h/%b", out_valid,
               out_max, out_min, out_all_equal, exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
    step();
  endtask

  task automatic test_hold_stall;
    out_ready = 1'b0;
    send_frame(32'h01234567, 8, 0);
    exp_v = sb_q.pop_front();
    in_valid = 1'b1;
    in_data  = 4'h4;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b01) begin
        n_bad++;
        $display("FAIL stall_handshake[%0d]: got rdy=%b v=%b required rdy=0 v=1", i, in_ready, out_valid);
      end
      n_cmp++;
      if ({out_max, out_min, out_all_equal} !== exp_v) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got %h/%h/%b required %h/%h/%b", i,
                 out_max, out_min, out_all_equal, exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 4'bxxxx;
    n_cmp++;
    if ({in_ready, out_valid, dut.count_r} !== 6'b100000) begin
      n_bad++;
      $display("FAIL stall_release: got rdy=%b v=%b count=%0d required rdy=1 v=0 count=0",
               in_ready, out_valid, dut.count_r);
    end
  endtask

  task automatic test_random_gaps;
    logic [31:0] f;
    for (int k = 0; k < 4; k++) begin
      f = $urandom();
      send_frame(f, 8, 50);
      wait_result(ok);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (!ok || {out_max, out_min, out_all_equal} !== exp_v) begin
        n_bad++;
        $display("FAIL random_frame[%0d]: got v=%b %h/%h/%b required %h/%h/%b", k, out_valid,
                 out_max, out_min, out_all_equal, exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
      step();
    end
  endtask

  task automatic test_mid_reset;
    send_frame(32'h0000FFFF, 4, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, dut.count_r} !== 6'b010000) begin
      n_bad++;
      $display("FAIL midreset_state: got v=%b rdy=%b count=%0d required v=0 rdy=1 count=0",
               out_valid, in_ready, dut.count_r);
    end
    send_frame(32'h08888888, 8, 0);
    wait_result(ok);
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (!ok || {out_max, out_min, out_all_equal} !== exp_v) begin
      n_bad++;
      $display("FAIL midreset_frame: got v=%b %h/%h/%b required %h/%h/%b", out_valid,
               out_max, out_min, out_all_equal, exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
    step();
  endtask

  task automatic test_count1;
    in_valid1 = 1'b1;
    in_data1  = 4'hA;
    sb1_q.push_back({4'hA, 4'hA, 1'b1});
    step();
    in_data1 = 4'h0;
    sb1_q.push_back({4'h0, 4'h0, 1'b1});
    exp_v = sb1_q.pop_front();
    n_cmp++;
    if ({out_valid1, in_ready1} !== 2'b10 || {out_max1, out_min1, out_all_equal1} !== exp_v) begin
      n_bad++;
      $display("FAIL count1_first: got v=%b rdy=%b %h/%h/%b required v=1 rdy=0 %h/%h/%b",
               out_valid1, in_ready1, out_max1, out_min1, out_all_equal1,
               exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
    step();
    step();
    in_valid1 = 1'b0;
    exp_v = sb1_q.pop_front();
    n_cmp++;
    if (out_valid1 !== 1'b1 || {out_max1, out_min1, out_all_equal1} !== exp_v) begin
      n_bad++;
      $display("FAIL count1_second: got v=%b %h/%h/%b required v=1 %h/%h/%b",
               out_valid1, out_max1, out_min1, out_all_equal1, exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_all_equal();
    test_hold_stall();
    test_random_gaps();
    test_mid_reset();
    test_count1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
